// File: rtl/lsu_ctrl.sv
// Load/store unit: runs one data-memory transaction per start over a req/ack bus,
// building byte enables and replicated write data, and extending load results.
module lsu_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_misaligned,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_next;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sd_q, sd_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_data_d;
  logic        err_mis_d, err_ill_d, err_to_d;

  logic [3:0]  be_lat;
  logic [31:0] wdata_lat;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rext;
  logic        req_illegal, req_misaligned;

  // Lane pattern and replicated write data from the latched access.
  always_comb begin
    be_lat    = 4'b1111;
    wdata_lat = sd_q;
    case (f3_q[1:0])
      2'b00: begin
        be_lat    = 4'b0001 << addr_q[1:0];
        wdata_lat = {4{sd_q[7:0]}};
      end
      2'b01: begin
        be_lat    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lat = {2{sd_q[15:0]}};
      end
      default: begin
        be_lat    = 4'b1111;
        wdata_lat = sd_q;
      end
    endcase
  end

  always_comb begin
    rbyte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   rbyte = mem_rdata[7:0];
      2'b01:   rbyte = mem_rdata[15:8];
      2'b10:   rbyte = mem_rdata[23:16];
      default: rbyte = mem_rdata[31:24];
    endcase
    rhalf = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rext = {{24{rbyte[7]}}, rbyte};
      3'b001:  rext = {{16{rhalf[15]}}, rhalf};
      3'b100:  rext = {24'b0, rbyte};
      3'b101:  rext = {16'b0, rhalf};
      default: rext = mem_rdata;
    endcase
  end

  // Legality is judged on the raw inputs so errors can finish in the accept cycle.
  always_comb begin
    req_illegal = 1'b1;
    case (funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = mem_write;
      default:                req_illegal = 1'b1;
    endcase
    if (!(mem_read ^ mem_write)) req_illegal = 1'b1;
    req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_next  = state;
    addr_d      = addr_q;
    sd_d        = sd_q;
    f3_d        = f3_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    load_data_d = load_data;
    err_mis_d   = err_misaligned;
    err_ill_d   = err_illegal;
    err_to_d    = err_timeout;
    case (state)
      IDLE: begin
        cnt_d = 8'd0;
        if (start) begin
          addr_d = addr;
          sd_d   = store_data;
          f3_d   = funct3;
          we_d   = mem_write;
          if (req_illegal) begin
            state_next = DONE;
            err_ill_d  = 1'b1;
          end else if (req_misaligned) begin
            state_next = DONE;
            err_mis_d  = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // An ack arriving on the final count still wins over the timeout.
        if (mem_ack) begin
          state_next = DONE;
          cnt_d      = 8'd0;
          if (!we_q) load_data_d = rext;
        end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
          state_next = DONE;
          cnt_d      = 8'd0;
          err_to_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_next  = IDLE;
        load_data_d = 32'd0;
        err_mis_d   = 1'b0;
        err_ill_d   = 1'b0;
        err_to_d    = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr_q         <= 32'd0;
      sd_q           <= 32'd0;
      f3_q           <= 3'd0;
      we_q           <= 1'b0;
      cnt_q          <= 8'd0;
      load_data      <= 32'd0;
      err_misaligned <= 1'b0;
      err_illegal    <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= state_next;
      addr_q         <= addr_d;
      sd_q           <= sd_d;
      f3_q           <= f3_d;
      we_q           <= we_d;
      cnt_q          <= cnt_d;
      load_data      <= load_data_d;
      err_misaligned <= err_mis_d;
      err_illegal    <= err_ill_d;
      err_timeout    <= err_to_d;
    end
  end

  // Bus outputs are gated to the REQ state so the bus sees zeros while idle.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? be_lat : 4'b0000;
  assign mem_wdata = mem_req ? wdata_lat : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: stores, loads with extension,
// alignment/illegal errors, bus timeout, start-while-busy and mid-transaction reset.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        err_misaligned;
  logic        err_illegal;
  logic        err_timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .store_data(store_data), .funct3(funct3),
    .busy(busy), .done(done), .load_data(load_data),
    .err_misaligned(err_misaligned), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge, then clears the request inputs.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] sd, input logic [2:0] f3);
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    store_data = sd;
    funct3     = f3;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = 32'd0;
    store_data = 32'd0;
    funct3     = 3'd0;
  endtask

  // Load with a number of wait cycles before ack; checks the extended result.
  task automatic doLoad(input string tag, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] rdata, input int waits,
                        input logic [3:0] exp_be, input logic [31:0] exp_data);
    applyStimulus(1'b1, 1'b0, a, 32'd0, f3);
    checkOutput({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    for (int i = 0; i < waits; i++) tick();
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_data"}, load_data, exp_data);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int req_cycles;
    reset = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'd0; store_data = 32'd0; funct3 = 3'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_be", 32'(mem_be), 32'd0);
    checkOutput("rst_ldata", load_data, 32'd0);
    reset = 1'b0;
    tick();

    // SW, zero-wait bus: done in cycle 2
    applyStimulus(1'b0, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 3'b010);
    checkOutput("sw_req", 32'(mem_req), 32'd1);
    checkOutput("sw_addr", mem_addr, 32'h1000_0008);
    checkOutput("sw_be", 32'(mem_be), 32'hF);
    checkOutput("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("sw_we", 32'(mem_we), 32'd1);
    checkOutput("sw_done_c1", 32'(done), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("sw_done_c2", 32'(done), 32'd1);
    checkOutput("sw_errs", {29'd0, err_misaligned, err_illegal, err_timeout}, 32'd0);
    checkOutput("sw_req_off", 32'(mem_req), 32'd0);
    tick();
    checkOutput("sw_idle", 32'(busy), 32'd0);

    // Loads with extension
    applyStimulus(1'b1, 1'b0, 32'h0000_0103, 32'd0, 3'b000);
    checkOutput("lb_addr", mem_addr, 32'h0000_0100);
    tick(); tick(); tick();
    checkOutput("lb_stable_be", 32'(mem_be), 32'h8);
    checkOutput("lb_stable_req", 32'(mem_req), 32'd1);
    mem_rdata = 32'h80FF_1234;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("lb_done", 32'(done), 32'd1);
    checkOutput("lb_data", load_data, 32'hFFFF_FF80);
    tick();
    checkOutput("lb_data_clr", load_data, 32'd0);
    doLoad("lbu", 32'h0000_0103, 3'b100, 32'h80FF_1234, 3, 4'b1000, 32'h0000_0080);
    doLoad("lhu", 32'h0000_0102, 3'b101, 32'h80FF_1234, 1, 4'b1100, 32'h0000_80FF);
    doLoad("lh_hi", 32'h0000_0102, 3'b001, 32'h80FF_1234, 0, 4'b1100, 32'hFFFF_80FF);
    doLoad("lh_lo", 32'h0000_0100, 3'b001, 32'h80FF_1234, 2, 4'b0011, 32'h0000_1234);
    doLoad("lb_l1", 32'h0000_0101, 3'b000, 32'h80FF_1234, 0, 4'b0010, 32'h0000_0012);
    doLoad("lw", 32'h0000_0100, 3'b010, 32'h80FF_1234, 0, 4'b1111, 32'h80FF_1234);

    // Misaligned accesses finish in cycle 1 without a bus request
    applyStimulus(1'b0, 1'b1, 32'h0000_0201, 32'h1234_5678, 3'b001);
    checkOutput("sh_mis_done", 32'(done), 32'd1);
    checkOutput("sh_mis_err", 32'(err_misaligned), 32'd1);
    checkOutput("sh_mis_req", 32'(mem_req), 32'd0);
    tick();
    checkOutput("sh_mis_req2", 32'(mem_req), 32'd0);
    checkOutput("sh_mis_clr", 32'(err_misaligned), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0202, 32'd0, 3'b010);
    checkOutput("lw_mis_done", 32'(done), 32'd1);
    checkOutput("lw_mis_err", 32'(err_misaligned), 32'd1);
    checkOutput("lw_mis_req", 32'(mem_req), 32'd0);
    tick();

    // Timeout: exactly 15 request cycles, then a late ack is ignored
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'd0, 3'b010);
    req_cycles = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cycles++;
      tick();
    end
    checkOutput("to_cycles", 32'(req_cycles), 32'd15);
    checkOutput("to_done", 32'(done), 32'd1);
    checkOutput("to_err", 32'(err_timeout), 32'd1);
    mem_ack = 1'b1;
    tick();
    checkOutput("to_late_busy", 32'(busy), 32'd0);
    tick();
    mem_ack = 1'b0;
    checkOutput("to_late_done", 32'(done), 32'd0);

    // Illegal requests
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'd0, 3'b011);
    checkOutput("ill_f3_done", 32'(done), 32'd1);
    checkOutput("ill_f3_err", 32'(err_illegal), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'd0, 3'b100);
    checkOutput("ill_sbu_err", 32'(err_illegal), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0000, 32'd0, 3'b010);
    checkOutput("ill_both_done", 32'(done), 32'd1);
    checkOutput("ill_both_err", 32'(err_illegal), 32'd1);
    checkOutput("ill_both_req", 32'(mem_req), 32'd0);
    tick();

    // start while busy is ignored
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'd0, 3'b010);
    start = 1'b1; mem_write = 1'b1; addr = 32'h0000_0999; funct3 = 3'b000;
    tick();
    checkOutput("busy_addr", mem_addr, 32'h0000_0300);
    checkOutput("busy_we", 32'(mem_we), 32'd0);
    start = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("busy_done", 32'(done), 32'd1);
    checkOutput("busy_data", load_data, 32'hCAFE_F00D);
    start = 1'b1;
    tick();
    start = 1'b0; mem_write = 1'b0; addr = 32'd0;
    checkOutput("busy_no_second", 32'(busy), 32'd0);
    tick();
    checkOutput("busy_no_second2", 32'(busy), 32'd0);

    // Reset in the second REQ cycle aborts without a done pulse
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'd0, 3'b010);
    tick();
    checkOutput("rstreq_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstreq_req_off", 32'(mem_req), 32'd0);
    checkOutput("rstreq_busy", 32'(busy), 32'd0);
    checkOutput("rstreq_done", 32'(done), 32'd0);
    tick();
    checkOutput("rstreq_done2", 32'(done), 32'd0);

    // SB to byte lane 3 after the aborted transaction
    applyStimulus(1'b0, 1'b1, 32'h0000_0003, 32'h0000_00A5, 3'b000);
    checkOutput("sb_be", 32'(mem_be), 32'h8);
    checkOutput("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_addr", mem_addr, 32'h0000_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("sb_done", 32'(done), 32'd1);
    checkOutput("sb_errs", {29'd0, err_misaligned, err_illegal, err_timeout}, 32'd0);
    tick();

    // SH upper half
    applyStimulus(1'b0, 1'b1, 32'h0000_0012, 32'hFFFF_BEEF, 3'b001);
    checkOutput("sh_be", 32'(mem_be), 32'hC);
    checkOutput("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("sh_done", 32'(done), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU.
- Takes ALUResult as the effective address, plus rs2 store data and funct3, and runs one data-memory transaction over a req/ack bus.
- Generates byte enables and lane-replicated write data.
- Extracts and sign/zero-extends load data; flags misaligned, illegal and timed-out accesses.
- Holds the core via busy until done.

Parameters:
TIMEOUT, 15, max cycles in REQ without mem_ack before abort (1..255)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
mem_read  input  1  load request
mem_write  input  1  store request
addr  input  32  effective address (ALUResult)
store_data  input  32  rs2 value
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result, valid when done && load && no error
err_misaligned  output  1  valid with done
err_illegal  output  1  valid with done
err_timeout  output  1  valid with done
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  32  word-aligned address {a[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated write data
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  bus completion; ignored outside REQ

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; timeout counter 0. Takes effect at the next edge even mid-transaction: mem_req drops and no done is issued.
- States:
  - IDLE: on start with (mem_read ^ mem_write), latch addr, store_data, funct3, we=mem_write, then check:
    - Illegal: funct3 not in {000,001,010} for stores or not in {000,001,010,100,101} for loads -> DONE, err_illegal=1.
    - Misaligned: halfword with a[0]=1, or word with a[1:0]!=0 -> DONE, err_misaligned=1.
    - Otherwise -> REQ.
    - start with both or neither of mem_read/mem_write -> DONE, err_illegal=1.
    - start low -> stay IDLE.
  - REQ: mem_req=1; mem_we, mem_addr, mem_be and mem_wdata stay stable from latched values until ack. Counter increments each REQ cycle.
    - mem_ack=1 -> DONE. For loads, capture the extracted value into load_data.
    - Counter reaches TIMEOUT with no ack -> DONE, err_timeout=1, mem_req deasserted.
    - mem_ack in the same cycle as the TIMEOUT count is treated as a successful ack.
  - DONE: done=1 for exactly one cycle; err flags and load_data are valid this cycle. -> IDLE. start in DONE is ignored.
- Error flags and load_data clear to 0 on leaving DONE.
- Byte enables and write data, by latched a[1:0]:
  - B: be=4'b0001<<a[1:0], wdata={4{sd[7:0]}}
  - H: be = a[1] ? 4'b1100 : 4'b0011, wdata={2{sd[15:0]}}
  - W: be=4'b1111, wdata=sd
  - Loads drive the same be pattern with mem_we=0.
- Load extract: byte = rdata[8*a[1:0] +: 8], half = rdata[16*a[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata through.
- Latency: start accepted at edge 0; mem_req high from cycle 1; ack sampled at cycle k>=1; done at cycle k+1.
  - Zero-wait bus: done at cycle 2.
  - Error detected at accept: done at cycle 1, no mem_req ever.
- busy is combinational from state and is 1 in REQ and DONE.

Test Plan:
- SW addr=0x1000_0008, sd=0xDEAD_BEEF, ack on first req cycle -> mem_addr=0x1000_0008, be=1111, wdata=0xDEADBEEF, we=1; done at cycle 2; no errors.
- LB addr=0x0000_0103, rdata=0x80FF_1234, ack after 3 waits -> be=1000; load_data=0xFFFF_FF80; LBU same access -> 0x0000_0080; LHU addr 0x102 -> 0x0000_80FF.
- SH addr=0x0000_0201 -> done at cycle 1, err_misaligned=1, mem_req never asserted; LW addr 0x0000_0202 -> same.
- Load, no ack, TIMEOUT=15 -> mem_req high for exactly 15 cycles, then done with err_timeout=1; late ack in IDLE ignored (no done).
- funct3=011 load, or mem_read=mem_write=1 -> done cycle 1, err_illegal=1; start asserted while busy -> no second transaction.
- reset asserted in REQ cycle 2 -> next edge mem_req=0, busy=0, done never pulses; new SB addr 0x3 afterwards -> be=1000, wdata byte replicated.
